// File: rtl/up_down_mod_counter.sv
// Bidirectional modulo-MOD counter with clear, clamped parallel load, wrap or
// saturate behaviour at the boundaries, and registered one-cycle event pulses.
module up_down_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 16,
  parameter bit SATURATE  = 1'b0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_aH,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  // One bit wider so MOD == 2**WIDTH is representable in the load clamp compare.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);

  generate
    if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_params
      $error("up_down_mod_counter: illegal MOD/RESET_VAL for WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_sat;

  assign at_max = (count == MAX_VAL);
  assign at_min = (count == '0);

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    next_sat   = 1'b0;
    if (clear) begin
      next_count = RST_VAL;
    end else if (load) begin
      next_count = ({1'b0, load_val} < MOD_W) ? load_val : MAX_VAL;
    end else if (inc && !dec) begin
      if (!at_max) begin
        next_count = count + WIDTH'(1);
      end else if (SATURATE) begin
        next_sat = 1'b1;
      end else begin
        next_count = '0;
        next_wrap  = 1'b1;
      end
    end else if (dec && !inc) begin
      if (!at_min) begin
        next_count = count - WIDTH'(1);
      end else if (SATURATE) begin
        next_sat = 1'b1;
      end else begin
        next_count = MAX_VAL;
        next_wrap  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
      sat   <= next_sat;
    end
  end

endmodule

// File: tb/tb_up_down_mod_counter.sv
// Directed bench: one wrapping instance (MOD=10, reset 0) and one saturating
// instance (MOD=10, reset 3), with hand-computed expectations.
module tb_up_down_mod_counter;

  logic       clk = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic       w_rst, w_clear, w_load, w_inc, w_dec;
  logic [3:0] w_load_val, w_count;
  logic       w_at_max, w_at_min, w_wrap, w_sat;

  logic       s_rst, s_clear, s_load, s_inc, s_dec;
  logic [3:0] s_load_val, s_count;
  logic       s_at_max, s_at_min, s_wrap, s_sat;

  up_down_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0), .RESET_VAL(0)) dut_w (
    .clk(clk), .rst_aH(w_rst), .clear(w_clear), .load(w_load), .load_val(w_load_val),
    .inc(w_inc), .dec(w_dec), .count(w_count), .at_max(w_at_max), .at_min(w_at_min),
    .wrap(w_wrap), .sat(w_sat)
  );

  up_down_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b1), .RESET_VAL(3)) dut_s (
    .clk(clk), .rst_aH(s_rst), .clear(s_clear), .load(s_load), .load_val(s_load_val),
    .inc(s_inc), .dec(s_dec), .count(s_count), .at_max(s_at_max), .at_min(s_at_min),
    .wrap(s_wrap), .sat(s_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic c, input logic l, input logic [3:0] lv,
                         input logic i, input logic d);
    w_clear = c; w_load = l; w_load_val = lv; w_inc = i; w_dec = d;
  endtask

  task automatic drive_s(input logic c, input logic l, input logic [3:0] lv,
                         input logic i, input logic d);
    s_clear = c; s_load = l; s_load_val = lv; s_inc = i; s_dec = d;
  endtask

  task automatic check_w(input string tag, input logic [3:0] c, input logic wr, input logic st);
    check({tag, "_count"}, 32'(w_count), 32'(c));
    check({tag, "_wrap"}, 32'(w_wrap), 32'(wr));
    check({tag, "_sat"}, 32'(w_sat), 32'(st));
  endtask

  task automatic check_s(input string tag, input logic [3:0] c, input logic wr, input logic st);
    check({tag, "_count"}, 32'(s_count), 32'(c));
    check({tag, "_wrap"}, 32'(s_wrap), 32'(wr));
    check({tag, "_sat"}, 32'(s_sat), 32'(st));
  endtask

  initial begin
    w_rst = 1'b1; s_rst = 1'b1;
    drive_w(0, 0, 4'd0, 0, 0);
    drive_s(0, 0, 4'd0, 0, 0);
    #12;
    // Reset state, before any clock edge has been seen under reset release.
    check_w("w_reset", 4'd0, 1'b0, 1'b0);
    check("w_reset_at_min", 32'(w_at_min), 32'd1);
    check("w_reset_at_max", 32'(w_at_max), 32'd0);
    check_s("s_reset", 4'd3, 1'b0, 1'b0);
    check("s_reset_at_min", 32'(s_at_min), 32'd0);
    @(negedge clk);
    w_rst = 1'b0; s_rst = 1'b0;
    #1;

    // Wrap mode: ten increments run 1..9 then wrap to 0.
    drive_w(0, 0, 4'd0, 1, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_w($sformatf("w_inc%0d", i), 4'(i % 10), (i == 10), 1'b0);
      check($sformatf("w_inc%0d_at_max", i), 32'(w_at_max), 32'(i == 9));
      check($sformatf("w_inc%0d_at_min", i), 32'(w_at_min), 32'(i == 10));
    end

    // Decrement from 0 wraps to 9; the pulse clears on the next idle cycle.
    drive_w(0, 0, 4'd0, 0, 1); tick();
    check_w("w_dec_wrap", 4'd9, 1'b1, 1'b0);
    check("w_dec_wrap_at_max", 32'(w_at_max), 32'd1);
    drive_w(0, 0, 4'd0, 0, 0); tick();
    check_w("w_idle", 4'd9, 1'b0, 1'b0);

    // inc and dec together at the top boundary: no movement, no pulse.
    drive_w(0, 0, 4'd0, 1, 1); tick();
    check_w("w_incdec_at_max", 4'd9, 1'b0, 1'b0);

    // Loads, including clamping of out-of-range values.
    drive_w(0, 1, 4'd4, 0, 0); tick();
    check_w("w_load4", 4'd4, 1'b0, 1'b0);
    drive_w(0, 1, 4'd12, 0, 0); tick();
    check_w("w_load12_clamp", 4'd9, 1'b0, 1'b0);
    drive_w(0, 1, 4'd3, 1, 0); tick();
    check_w("w_load3_with_inc", 4'd3, 1'b0, 1'b0);
    drive_w(0, 1, 4'd10, 0, 0); tick();
    check_w("w_load10_clamp", 4'd9, 1'b0, 1'b0);
    drive_w(0, 1, 4'd15, 0, 1); tick();
    check_w("w_load15_with_dec", 4'd9, 1'b0, 1'b0);
    drive_w(0, 0, 4'd0, 1, 0); tick();
    check_w("w_wrap_again", 4'd0, 1'b1, 1'b0);
    drive_w(0, 1, 4'd5, 0, 0); tick();
    check_w("w_load_clears_wrap", 4'd5, 1'b0, 1'b0);
    drive_w(1, 1, 4'd8, 1, 0); tick();
    check_w("w_clear_over_load", 4'd0, 1'b0, 1'b0);

    // Asynchronous reset asserted between edges while counting up.
    drive_w(0, 1, 4'd6, 0, 0); tick();
    drive_w(0, 0, 4'd0, 1, 0); tick();
    check_w("w_pre_rst", 4'd7, 1'b0, 1'b0);
    #3 w_rst = 1'b1;
    #1;
    check_w("w_async_rst", 4'd0, 1'b0, 1'b0);
    repeat (2) tick();
    check_w("w_rst_held", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    w_rst = 1'b0;
    tick();
    check_w("w_after_rst", 4'd1, 1'b0, 1'b0);
    drive_w(0, 0, 4'd0, 0, 0);

    // Saturate mode.
    drive_s(0, 1, 4'd9, 0, 0); tick();
    check_s("s_load9", 4'd9, 1'b0, 1'b0);
    drive_s(0, 0, 4'd0, 1, 0); tick();
    check_s("s_inc_hold1", 4'd9, 1'b0, 1'b1);
    tick();
    check_s("s_inc_hold2", 4'd9, 1'b0, 1'b1);
    drive_s(0, 0, 4'd0, 0, 1); tick();
    check_s("s_dec8", 4'd8, 1'b0, 1'b0);
    drive_s(0, 1, 4'd0, 0, 0); tick();
    check_s("s_load0", 4'd0, 1'b0, 1'b0);
    drive_s(0, 0, 4'd0, 0, 1); tick();
    check_s("s_dec_hold", 4'd0, 1'b0, 1'b1);
    check("s_dec_hold_at_min", 32'(s_at_min), 32'd1);
    drive_s(0, 0, 4'd0, 1, 1); tick();
    check_s("s_incdec_at_min", 4'd0, 1'b0, 1'b0);
    drive_s(0, 0, 4'd0, 1, 0); tick();
    check_s("s_inc1", 4'd1, 1'b0, 1'b0);
    drive_s(1, 1, 4'd7, 0, 0); tick();
    check_s("s_clear_over_load", 4'd3, 1'b0, 1'b0);
    drive_s(0, 0, 4'd0, 0, 0); tick();
    check_s("s_idle", 4'd3, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/up_down_mod_counter.md
Name: up_down_mod_counter

Overview:
- Parametrised successor to the single-mode incrementing counter.
- Bidirectional, modulo-N counter with synchronous clear, parallel load, wrap or saturate mode, and registered boundary event pulses.
- Used for ROB/IQ pointer tracking, credit counting and occupancy counters where depth is not a power of two and underflow/overflow must be observable.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 16, modulus; legal range 2 to 2**WIDTH; count spans 0..MOD-1.
- SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries.
- RESET_VAL, 0, value loaded on reset and clear; must be < MOD.

Ports:
- clk  input  1  clock, rising-edge.
- rst_aH  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous clear to RESET_VAL.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- inc  input  1  count up by one.
- dec  input  1  count down by one.
- count  output  WIDTH  current count, registered.
- at_max  output  1  count == MOD-1, combinational from count.
- at_min  output  1  count == 0, combinational from count.
- wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.
- sat  output  1  registered one-cycle pulse: an increment or decrement was blocked at a boundary on the previous edge.

Behaviour:
- Reset: rst_aH high forces count=RESET_VAL, wrap=0, sat=0 immediately, with no clock required. Reset is held for its full duration. It overrides any in-flight operation. The first edge after deassertion acts on inputs normally.
- Priority per edge: clear > load > inc/dec.
- clear: count<=RESET_VAL; wrap<=0; sat<=0. load/inc/dec are ignored.
- load: count<=load_val if load_val<MOD, else count<=MOD-1 (clamped). wrap<=0; sat<=0. inc/dec are ignored.
- inc&~dec:
  - count<MOD-1: count+1.
  - count==MOD-1 and SATURATE=0: count<=0, wrap<=1.
  - count==MOD-1 and SATURATE=1: count held, sat<=1.
- dec&~inc:
  - count>0: count-1.
  - count==0 and SATURATE=0: count<=MOD-1, wrap<=1.
  - count==0 and SATURATE=1: count held, sat<=1.
- inc&dec together: net zero; count held, wrap<=0, sat<=0.
- No operation: count held; wrap and sat return to 0. Pulses last exactly one cycle unless the boundary event repeats.
- Latency: one edge from input to count. at_max/at_min track count in the same cycle. wrap/sat assert in the same cycle as the updated count.
- Arithmetic: modulo compare against MOD-1 and 0; no reliance on natural 2**WIDTH rollover, so non-power-of-two MOD is exact. When MOD==2**WIDTH, behaviour is identical to natural rollover.
- Build is built from register and adder cells plus muxing. Elaboration error if MOD<2, MOD>2**WIDTH, or RESET_VAL>=MOD.

Test Plan:
- WIDTH=4, MOD=10, SATURATE=0: reset, then 10 inc cycles -> count 1..9, then 0. wrap=1 only in the cycle count shows 0. at_max=1 when count=9.
- Same config, count=0, one dec -> count=9, wrap=1 for one cycle; next idle cycle -> wrap=0, count=9.
- SATURATE=1, MOD=10: count=9, two inc cycles -> count stays 9, sat=1 both cycles. Then dec -> count=8, sat=0. From 0, dec -> count=0, sat=1.
- load_val=12 with MOD=10 -> count=9. Same cycle load=1, clear=1 -> count=RESET_VAL. load=1 with inc=1 and load_val=3 -> count=3, no wrap.
- inc=dec=1 at count=9 (wrap mode) -> count stays 9, wrap=0, sat=0.
- Assert rst_aH mid-cycle between edges while count=7 and inc=1 -> count=RESET_VAL immediately and stays there while held. After release, the next edge with inc=1 gives RESET_VAL+1.
